muldiv_seq: RTL

- Iterative radix-2 multiply/divide sequencer for the `mult` / `div` flags produced by the instruction decoder.
- Accepts one operation at a time from the execute stage and steps an internal shift/add-subtract datapath one bit per cycle.
- Returns the result plus the destination-register tag with a single-cycle done pulse for writeback.
- Owns the busy indication the execute stage uses to stall issue while a multi-cycle op is in flight.

---
 rtl/muldiv_seq.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - radix-2 iterative multiply/divide sequencer, one bit per cycle.
// Define MULDIV_DIV_EN to build the restoring divider; otherwise divide requests pulse div_trap.
module muldiv_seq #(
  parameter int RV = 32,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          is_div,
  input  logic [RV-1:0] a,
  input  logic [RV-1:0] b,
  input  logic [3:0]    rd_in,
  input  logic          kill,
  output logic          busy,
  output logic          done,
  output logic [RV-1:0] result,
  output logic [RV-1:0] remainder,
  output logic [3:0]    rd_out,
  output logic          div_trap
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [RV-1:0] acc;      // product accumulator, or partial remainder
  logic [RV-1:0] x;        // multiplicand, or dividend shifting out / quotient shifting in
  logic [RV-1:0] y;        // multiplier, or divisor
  logic [RV-1:0] res_q;
  logic [3:0]    rd_q;
  logic [3:0]    rd_hold;
  logic          trap_q;
  logic          accept;
  logic          trap_req;
  logic [RV-1:0] step_acc;
  logic [RV-1:0] step_x;
  logic [RV-1:0] step_y;
  logic [RV-1:0] fin_res;

`ifdef MULDIV_DIV_EN
  logic          op_div;
  logic [RV-1:0] rem_q;
  logic [RV-1:0] fin_rem;
  logic [RV:0]   rem_sh;
  logic [RV:0]   diff;

  assign rem_sh   = {acc, x[RV-1]};
  assign diff     = rem_sh - {1'b0, y};
  assign accept   = start && !kill && (state == IDLE);
  assign trap_req = 1'b0;
  assign fin_res  = op_div ? x : acc;
  assign fin_rem  = op_div ? acc : '0;
`else
  assign accept   = start && !kill && !is_div && (state == IDLE);
  assign trap_req = start && !kill && is_div && (state == IDLE);
  assign fin_res  = acc;
`endif

  always_comb begin
    step_acc = y[0] ? acc + x : acc;
    step_x   = x << 1;
    step_y   = y >> 1;
`ifdef MULDIV_DIV_EN
    // diff[RV] is the borrow: set means rem_sh < divisor, so restore
    if (op_div) begin
      step_acc = diff[RV] ? rem_sh[RV-1:0] : diff[RV-1:0];
      step_x   = {x[RV-2:0], ~diff[RV]};
      step_y   = y;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      acc     <= '0;
      x       <= '0;
      y       <= '0;
      res_q   <= '0;
      rd_q    <= '0;
      rd_hold <= '0;
      trap_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      op_div  <= 1'b0;
      rem_q   <= '0;
`endif
    end else begin
      trap_q <= trap_req;
      case (state)
        IDLE: begin
          if (accept) begin
            state <= RUN;
            count <= CW'(RV - 1);
            acc   <= '0;
            x     <= a;
            y     <= b;
            rd_q  <= rd_in;
`ifdef MULDIV_DIV_EN
            op_div <= is_div;
`endif
          end
        end
        RUN: begin
          if (kill) begin
            state <= IDLE;
          end else begin
            acc <= step_acc;
            x   <= step_x;
            y   <= step_y;
            if (count == '0) state <= DONE;
            else             count <= count - CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          if (!kill) begin
            res_q   <= fin_res;
            rd_hold <= rd_q;
`ifdef MULDIV_DIV_EN
            rem_q   <= fin_rem;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Final values show through during DONE and are committed to the hold registers only if not killed
  assign busy     = (state != IDLE);
  assign done     = (state == DONE) && !kill;
  assign result   = (state == DONE) ? fin_res : res_q;
  assign rd_out   = (state == DONE) ? rd_q : rd_hold;
  assign div_trap = trap_q;
`ifdef MULDIV_DIV_EN
  assign remainder = (state == DONE) ? fin_rem : rem_q;
`else
  assign remainder = '0;
`endif

endmodule
